reorder_buffer: RTL and testbench

// - Circular in-order reorder buffer between decoder/issue and the regfile.
// - Allocates ROB ids, collects CDB results, answers operand queries, commits one entry per cycle.
// - Commit drives the regfile write port; a mispredicted branch at commit raises a global flush.
// - ROB id 0 is reserved ("no pending producer" in regfile); valid ids are 1..DEPTH.

---
 rtl/reorder_buffer_if.sv | 51 +++++
 rtl/reorder_buffer.sv | 156 +++++++++++++++
 tb/tb_reorder_buffer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Signal bundle between the reorder buffer and its neighbours: decoder/issue,
// CDB, operand queries, regfile commit port, store-commit and flush.
interface reorder_buffer_if #(
    parameter int ROB_ID_W = 4
);
    logic                dec_valid;
    logic [1:0]          dec_type;
    logic [4:0]          dec_rd;
    logic                dec_pred_taken;
    logic                rob_full;
    logic [ROB_ID_W-1:0] rob_next_id;

    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [31:0]         cdb_value;
    logic                cdb_taken;
    logic [31:0]         cdb_target;

    logic [ROB_ID_W-1:0] qry_id_a;
    logic [ROB_ID_W-1:0] qry_id_b;
    logic                qry_ready_a;
    logic                qry_ready_b;
    logic [31:0]         qry_value_a;
    logic [31:0]         qry_value_b;

    logic                to_rf_write_en;
    logic [4:0]          to_rf_reg_id;
    logic [31:0]         to_rf_data;
    logic [ROB_ID_W-1:0] to_rf_rob_id;
    logic                to_lsb_store_commit;
    logic                flush_out;
    logic [31:0]         flush_pc;

    modport master (
        output dec_valid, dec_type, dec_rd, dec_pred_taken,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
        output qry_id_a, qry_id_b,
        input  rob_full, rob_next_id, qry_ready_a, qry_ready_b, qry_value_a, qry_value_b,
        input  to_rf_write_en, to_rf_reg_id, to_rf_data, to_rf_rob_id,
        input  to_lsb_store_commit, flush_out, flush_pc
    );

    modport slave (
        input  dec_valid, dec_type, dec_rd, dec_pred_taken,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
        input  qry_id_a, qry_id_b,
        output rob_full, rob_next_id, qry_ready_a, qry_ready_b, qry_value_a, qry_value_b,
        output to_rf_write_en, to_rf_reg_id, to_rf_data, to_rf_rob_id,
        output to_lsb_store_commit, flush_out, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer with ids 1..2**ROB_ID_W-1 (id 0 = no producer).
// Define ROB_BYPASS_EN to forward a same-cycle CDB hit onto the operand queries.
module reorder_buffer #(
    parameter int ROB_ID_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    reorder_buffer_if.slave  rob
);
    localparam int                  NUM   = 2 ** ROB_ID_W;
    localparam logic [ROB_ID_W-1:0] DEPTH = '1;
    localparam logic [ROB_ID_W-1:0] ONE   = {{(ROB_ID_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_STORE  = 2'd2,
        T_RSVD   = 2'd3
    } rob_type_e;

    logic [NUM-1:0]      valid_q, ready_q;
    rob_type_e           type_q   [NUM];
    logic [4:0]          rd_q     [NUM];
    logic                pred_q   [NUM];
    logic                taken_q  [NUM];
    logic [31:0]         value_q  [NUM];
    logic [31:0]         target_q [NUM];

    logic [ROB_ID_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                full_q, flush_q;
    logic [31:0]         flush_pc_q;
    logic                rf_we_q, store_q;
    logic [4:0]          rf_reg_q;
    logic [31:0]         rf_data_q;
    logic [ROB_ID_W-1:0] rf_id_q;

    logic head_commit, mispredict, issue_fire, cdb_hit, reg_type;

    function automatic logic [ROB_ID_W-1:0] next_ptr(input logic [ROB_ID_W-1:0] p);
        return (p == DEPTH) ? ONE : p + ONE;
    endfunction

    // Commit looks only at pre-edge ready bits, so a CDB write never commits on its own edge.
    always_comb begin
        head_commit = valid_q[head_q] && ready_q[head_q];
        mispredict  = head_commit && (type_q[head_q] == T_BRANCH) &&
                      (taken_q[head_q] != pred_q[head_q]);
        reg_type    = (type_q[head_q] == T_REG) || (type_q[head_q] == T_RSVD);
        issue_fire  = rob.dec_valid && !full_q && !flush_q && !mispredict;
        cdb_hit     = rob.cdb_valid && !flush_q && (rob.cdb_rob_id != '0) &&
                      valid_q[rob.cdb_rob_id];
        head_d      = head_commit ? next_ptr(head_q) : head_q;
        tail_d      = issue_fire ? next_ptr(tail_q) : tail_q;
        unique case ({issue_fire, head_commit})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        if (mispredict) begin
            head_d  = ONE;
            tail_d  = ONE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= ONE;
            tail_q  <= ONE;
            count_q <= '0;
            full_q  <= 1'b0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH);
            if (mispredict) begin
                valid_q <= '0;
                ready_q <= '0;
            end else begin
                if (head_commit) valid_q[head_q] <= 1'b0;
                if (cdb_hit) ready_q[rob.cdb_rob_id] <= 1'b1;
                if (issue_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (issue_fire) begin
            type_q[tail_q] <= rob_type_e'(rob.dec_type);
            rd_q[tail_q]   <= rob.dec_rd;
            pred_q[tail_q] <= rob.dec_pred_taken;
        end
        if (cdb_hit) begin
            value_q[rob.cdb_rob_id]  <= rob.cdb_value;
            taken_q[rob.cdb_rob_id]  <= rob.cdb_taken;
            target_q[rob.cdb_rob_id] <= rob.cdb_target;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rf_we_q    <= 1'b0;
            rf_reg_q   <= '0;
            rf_data_q  <= '0;
            rf_id_q    <= '0;
            store_q    <= 1'b0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            rf_we_q    <= head_commit && reg_type && (rd_q[head_q] != 5'd0);
            rf_reg_q   <= head_commit ? rd_q[head_q] : 5'd0;
            rf_data_q  <= head_commit ? value_q[head_q] : 32'd0;
            rf_id_q    <= head_commit ? head_q : '0;
            store_q    <= head_commit && (type_q[head_q] == T_STORE);
            flush_q    <= mispredict;
            flush_pc_q <= mispredict ? target_q[head_q] : 32'd0;
        end
    end

    always_comb begin
        rob.qry_ready_a = valid_q[rob.qry_id_a] && ready_q[rob.qry_id_a];
        rob.qry_value_a = rob.qry_ready_a ? value_q[rob.qry_id_a] : 32'd0;
        rob.qry_ready_b = valid_q[rob.qry_id_b] && ready_q[rob.qry_id_b];
        rob.qry_value_b = rob.qry_ready_b ? value_q[rob.qry_id_b] : 32'd0;
`ifdef ROB_BYPASS_EN
        if (rob.cdb_valid && (rob.cdb_rob_id == rob.qry_id_a) && (rob.qry_id_a != '0) &&
            valid_q[rob.qry_id_a]) begin
            rob.qry_ready_a = 1'b1;
            rob.qry_value_a = rob.cdb_value;
        end
        if (rob.cdb_valid && (rob.cdb_rob_id == rob.qry_id_b) && (rob.qry_id_b != '0) &&
            valid_q[rob.qry_id_b]) begin
            rob.qry_ready_b = 1'b1;
            rob.qry_value_b = rob.cdb_value;
        end
`else
        // Queries see registered state only; a CDB result shows up one cycle later.
`endif
    end

    assign rob.rob_full            = full_q;
    assign rob.rob_next_id         = tail_q;
    assign rob.to_rf_write_en      = rf_we_q;
    assign rob.to_rf_reg_id        = rf_reg_q;
    assign rob.to_rf_data          = rf_data_q;
    assign rob.to_rf_rob_id        = rf_id_q;
    assign rob.to_lsb_store_commit = store_q;
    assign rob.flush_out           = flush_q;
    assign rob.flush_pc            = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a
// program-order queue model of the ROB.
module tb_reorder_buffer;
    localparam int W = 4;
`ifdef ROB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    reorder_buffer_if #(.ROB_ID_W(W)) bus ();
    reorder_buffer #(.ROB_ID_W(W)) dut (.clk_in(clk_in), .rst_in(rst_in), .rob(bus));

    int total = 0;
    int bad   = 0;

    // Reference model: ids in program order plus per-id contents.
    logic [W-1:0] exp_q[$];
    logic         m_ready [16];
    logic [31:0]  m_val   [16];
    logic [31:0]  m_tgt   [16];
    logic         m_taken [16];
    logic         m_pred  [16];
    logic [1:0]   m_type  [16];
    logic [4:0]   m_rd    [16];
    logic [W-1:0] m_next;
    logic         m_full, m_flush;
    logic         e_we, e_st, e_fl;
    logic [4:0]   e_reg;
    logic [31:0]  e_data, e_pc;
    logic [W-1:0] e_id;
    int           commits;

    logic         s_dv, s_pr, s_cv, s_ctk;
    logic [1:0]   s_dt;
    logic [4:0]   s_rd;
    logic [W-1:0] s_cid;
    logic [31:0]  s_cval, s_ctg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_q(input logic [W-1:0] id);
        foreach (exp_q[i]) if (exp_q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_ready[i] = 1'b0;
        m_next = 1; m_full = 0; m_flush = 0;
        e_we = 0; e_st = 0; e_fl = 0; e_reg = 0; e_data = 0; e_pc = 0; e_id = 0;
    endtask

    task automatic check_regs();
        chk("next_id", bus.rob_next_id, m_next);
        chk("full", bus.rob_full, m_full);
        chk("rf_we", bus.to_rf_write_en, e_we);
        chk("store_commit", bus.to_lsb_store_commit, e_st);
        chk("flush", bus.flush_out, e_fl);
        chk("flush_pc", bus.flush_pc, e_pc);
        if (e_we) begin
            chk("rf_reg", bus.to_rf_reg_id, e_reg);
            chk("rf_data", bus.to_rf_data, e_data);
            chk("rf_rob_id", bus.to_rf_rob_id, e_id);
        end
    endtask

    task automatic qry_exp(input logic [W-1:0] id, output logic r, output logic [31:0] v);
        r = in_q(id) && m_ready[id];
        v = r ? m_val[id] : 32'd0;
        if (BYP && s_cv && s_cid == id && id != 0 && in_q(id)) begin
            r = 1'b1;
            v = s_cval;
        end
    endtask

    task automatic step_a(input logic dv, input logic [1:0] dt, input logic [4:0] rd,
                          input logic pr, input logic cv, input logic [W-1:0] cid,
                          input logic [31:0] cval, input logic ctk, input logic [31:0] ctg,
                          input logic [W-1:0] qa, input logic [W-1:0] qb);
        logic r;
        logic [31:0] v;
        s_dv = dv; s_dt = dt; s_rd = rd; s_pr = pr;
        s_cv = cv; s_cid = cid; s_cval = cval; s_ctk = ctk; s_ctg = ctg;
        bus.dec_valid = dv; bus.dec_type = dt; bus.dec_rd = rd; bus.dec_pred_taken = pr;
        bus.cdb_valid = cv; bus.cdb_rob_id = cid; bus.cdb_value = cval;
        bus.cdb_taken = ctk; bus.cdb_target = ctg;
        bus.qry_id_a = qa; bus.qry_id_b = qb;
        #1;
        qry_exp(qa, r, v);
        chk("qry_ready_a", bus.qry_ready_a, r);
        chk("qry_value_a", bus.qry_value_a, v);
        qry_exp(qb, r, v);
        chk("qry_ready_b", bus.qry_ready_b, r);
        chk("qry_value_b", bus.qry_value_b, v);
    endtask

    task automatic step_b();
        logic commit, mis, iss, cdb;
        logic [W-1:0] h;
        @(posedge clk_in);
        commit = (exp_q.size() > 0) && m_ready[exp_q[0]];
        h      = commit ? exp_q[0] : '0;
        mis    = commit && m_type[h] == 2'd1 && m_taken[h] != m_pred[h];
        iss    = s_dv && !m_full && !m_flush && !mis;
        cdb    = s_cv && !m_flush && s_cid != 0 && in_q(s_cid);
        e_we   = commit && (m_type[h] == 2'd0 || m_type[h] == 2'd3) && m_rd[h] != 0;
        e_reg  = commit ? m_rd[h] : 5'd0;
        e_data = commit ? m_val[h] : 32'd0;
        e_id   = h;
        e_st   = commit && m_type[h] == 2'd2;
        e_fl   = mis;
        e_pc   = mis ? m_tgt[h] : 32'd0;
        if (e_we) commits++;
        if (commit) void'(exp_q.pop_front());
        if (mis) begin
            exp_q.delete();
            m_next = 1;
        end else begin
            if (cdb) begin
                m_ready[s_cid] = 1'b1; m_val[s_cid] = s_cval;
                m_taken[s_cid] = s_ctk; m_tgt[s_cid] = s_ctg;
            end
            if (iss) begin
                exp_q.push_back(m_next);
                m_ready[m_next] = 1'b0; m_type[m_next] = s_dt;
                m_rd[m_next] = s_rd; m_pred[m_next] = s_pr;
                m_next = (m_next == 15) ? 4'd1 : m_next + 4'd1;
            end
        end
        m_full  = exp_q.size() == 15;
        m_flush = mis;
        #1;
        check_regs();
    endtask

    task automatic do_issue(input logic [1:0] dt, input logic [4:0] rd, input logic pr);
        step_a(1, dt, rd, pr, 0, 0, 0, 0, 0, 0, 0);
        step_b();
    endtask

    task automatic do_cdb(input logic [W-1:0] id, input logic [31:0] val, input logic tk,
                          input logic [31:0] tg);
        step_a(0, 0, 0, 0, 1, id, val, tk, tg, id, 0);
        step_b();
    endtask

    task automatic do_idle();
        step_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_b();
    endtask

    task automatic do_reset();
        bus.dec_valid = 0; bus.dec_type = 0; bus.dec_rd = 0; bus.dec_pred_taken = 0;
        bus.cdb_valid = 0; bus.cdb_rob_id = 0; bus.cdb_value = 0;
        bus.cdb_taken = 0; bus.cdb_target = 0; bus.qry_id_a = 0; bus.qry_id_b = 0;
        rst_in = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        commits = 0;
        do_reset();

        // Fill all 15 entries, then a refused 16th issue.
        for (int rd = 1; rd <= 15; rd++) begin
            chk("grant_id", bus.rob_next_id, rd);
            do_issue(0, 5'(rd), 0);
        end
        chk("full_after_15", bus.rob_full, 1);
        chk("tail_wrapped", bus.rob_next_id, 1);
        do_issue(0, 5'd9, 0);
        chk("refused_tail", bus.rob_next_id, 1);

        // Single REG commit.
        do_reset();
        do_issue(0, 5'd5, 0);
        do_cdb(1, 32'hDEADBEEF, 0, 0);
        do_idle();
        chk("single_we", bus.to_rf_write_en, 1);
        chk("single_reg", bus.to_rf_reg_id, 5);
        chk("single_data", bus.to_rf_data, 32'hDEADBEEF);
        chk("single_id", bus.to_rf_rob_id, 1);

        // Out-of-order completion, in-order commit.
        do_reset();
        do_issue(0, 5'd10, 0); do_issue(0, 5'd11, 0); do_issue(0, 5'd12, 0);
        do_cdb(3, 32'h33, 0, 0); do_cdb(2, 32'h22, 0, 0); do_cdb(1, 32'h11, 0, 0);
        do_idle(); chk("ooo_first", bus.to_rf_rob_id, 1);
        do_idle(); chk("ooo_second", bus.to_rf_rob_id, 2);
        do_idle(); chk("ooo_third", bus.to_rf_rob_id, 3);

        // Mispredicted branch flushes; issue at that edge and in the flush cycle is dropped.
        do_reset();
        do_issue(0, 5'd1, 0); do_issue(1, 5'd0, 0); do_issue(0, 5'd3, 0);
        do_cdb(1, 32'hA1, 0, 0);
        do_cdb(2, 32'h0, 1, 32'h100);
        do_issue(0, 5'd4, 0);
        chk("flush_pulse", bus.flush_out, 1);
        chk("flush_target", bus.flush_pc, 32'h100);
        chk("flush_tail", bus.rob_next_id, 1);
        step_a(1, 0, 5'd6, 0, 1, 3, 32'h77, 0, 0, 3, 0);
        step_b();
        chk("flush_drop", bus.flush_out, 0);
        chk("flush_blocked", bus.rob_next_id, 1);
        do_idle();
        chk("no_id3_commit", bus.to_rf_write_en, 0);

        // rd = 0 commit pops without a regfile write.
        do_reset();
        do_issue(0, 5'd0, 0); do_issue(0, 5'd7, 0);
        do_cdb(1, 32'h5, 0, 0); do_cdb(2, 32'h6, 0, 0);
        chk("rd0_no_we", bus.to_rf_write_en, 0);
        do_idle();
        chk("rd0_next_we", bus.to_rf_write_en, 1);
        chk("rd0_next_id", bus.to_rf_rob_id, 2);

        // Query racing the CDB write.
        do_reset();
        for (int i = 0; i < 4; i++) do_issue(0, 5'(i + 20), 0);
        step_a(0, 0, 0, 0, 1, 4, 32'h4444, 0, 0, 4, 4);
        chk("byp_same_cycle", bus.qry_ready_a, BYP);
        step_b();
        step_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        chk("byp_next_cycle", bus.qry_ready_a, 1);
        chk("byp_next_value", bus.qry_value_a, 32'h4444);
        step_b();

        // Sustained issue + commit across the pointer wrap.
        do_reset();
        commits = 0;
        for (int i = 0; i < 45; i++) begin
            logic cv;
            logic [W-1:0] cid;
            cv  = exp_q.size() > 0;
            cid = cv ? exp_q[$] : '0;
            step_a(1, 0, 5'($urandom_range(1, 31)), 0, cv, cid, $urandom, 0, 0, cid, 0);
            step_b();
            chk("wrap_next_nz", bus.rob_next_id != 0, 1);
            if (bus.to_rf_write_en) chk("wrap_id_nz", bus.to_rf_rob_id != 0, 1);
        end
        chk("wrap_commits", commits >= 40, 1);

        // Random traffic with a mid-run reset.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] cid, qa, qb;
            if (i == 200) do_reset();
            if (exp_q.size() > 0 && $urandom_range(0, 4) != 0)
                cid = exp_q[$urandom_range(0, exp_q.size() - 1)];
            else
                cid = W'($urandom_range(0, 15));
            qa = (exp_q.size() > 0) ? exp_q[$urandom_range(0, exp_q.size() - 1)] : '0;
            qb = (($urandom & 1) != 0) ? cid : W'($urandom_range(0, 15));
            step_a($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, cid, $urandom, 1'($urandom_range(0, 1)),
                   $urandom, qa, qb);
            step_b();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
